// File: rtl/neuron_lif_core.sv
// Leaky integrate-and-fire stage: integrates weighted axon spikes, leaks, thresholds, writes potential back.
// Latency: ts_end at edge k -> writeback/spike/done strobe high between edges k+2 and k+3.
// Backpressure: spike_ready_o high only in INTEGRATE; tick_i is only taken in IDLE.
module neuron_lif_core #(
    parameter bit SATURATE = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       spike_valid_i,
    input  logic [1:0] spike_type_i,
    output logic       spike_ready_o,
    input  logic       ts_end_i,
    input  logic [7:0] voltage_potential_i,
    input  logic [7:0] pos_threshold_i,
    input  logic [7:0] neg_threshold_i,
    input  logic [7:0] leak_value_i,
    input  logic [7:0] weight_type1_i,
    input  logic [7:0] weight_type2_i,
    input  logic [7:0] weight_type3_i,
    input  logic [7:0] weight_type4_i,
    input  logic [7:0] pos_reset_i,
    input  logic [7:0] neg_reset_i,
    output logic [7:0] ext_voltage_potential_o,
    output logic       ext_write_enable_o,
    output logic       spike_o,
    output logic       done_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INTEGRATE,
        S_LEAK,
        S_FIRE,
        S_WRITEBACK
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  weight_sel;
    logic [7:0]  addend;
    logic [8:0]  sum;
    logic [7:0]  sum_f;
    logic        fire_pos, fire_neg;

    always_comb begin
        weight_sel = weight_type1_i;
        case (spike_type_i)
            2'd0: weight_sel = weight_type1_i;
            2'd1: weight_sel = weight_type2_i;
            2'd2: weight_sel = weight_type3_i;
            2'd3: weight_sel = weight_type4_i;
            default: weight_sel = weight_type1_i;
        endcase
    end

    // One shared adder: leak in LEAK, selected weight otherwise.
    assign addend = (state_q == S_LEAK) ? leak_value_i : weight_sel;
    assign sum    = {acc_q[7], acc_q} + {addend[7], addend};

    always_comb begin
        sum_f = sum[7:0];
        if (SATURATE && (sum[8] != sum[7])) begin
            sum_f = sum[8] ? 8'h80 : 8'h7F;
        end
    end

    assign fire_pos = $signed(acc_q) >= $signed(pos_threshold_i);
    assign fire_neg = $signed(acc_q) <= $signed(neg_threshold_i);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (tick_i) begin
                    acc_d   = voltage_potential_i;
                    state_d = S_INTEGRATE;
                end
            end
            S_INTEGRATE: begin
                if (spike_valid_i) acc_d = sum_f;
                if (ts_end_i) state_d = S_LEAK;
            end
            S_LEAK: begin
                acc_d   = sum_f;
                state_d = S_FIRE;
            end
            S_FIRE:      state_d = S_WRITEBACK;
            S_WRITEBACK: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            acc_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    // Strobes are set only by FIRE, so they self-clear after the WRITEBACK cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ext_voltage_potential_o <= 8'h00;
            ext_write_enable_o      <= 1'b0;
            spike_o                 <= 1'b0;
            done_o                  <= 1'b0;
        end else begin
            ext_write_enable_o <= 1'b0;
            spike_o            <= 1'b0;
            done_o             <= 1'b0;
            if (state_q == S_FIRE) begin
                ext_write_enable_o <= 1'b1;
                done_o             <= 1'b1;
                if (fire_pos) begin
                    spike_o                 <= 1'b1;
                    ext_voltage_potential_o <= pos_reset_i;
                end else if (fire_neg) begin
                    ext_voltage_potential_o <= neg_reset_i;
                end else begin
                    ext_voltage_potential_o <= acc_q;
                end
            end
        end
    end

    assign spike_ready_o = (state_q == S_INTEGRATE);
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_neuron_lif_core.sv
// Directed bench for neuron_lif_core with hand-computed writeback values.
module tb_neuron_lif_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick, spk_vld, ts_end;
    logic [1:0] spk_type;
    logic [7:0] vpot, pos_th, neg_th, leak, w1, w2, w3, w4, pos_rst, neg_rst;
    logic       spk_rdy, ext_we, spike, done, busy;
    logic [7:0] ext_v;
    int         checks   = 0;
    int         failures = 0;
    int         we_seen;

    always #5 clk = ~clk;

    neuron_lif_core #(.SATURATE(1'b1)) dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_n),
        .tick_i                  (tick),
        .spike_valid_i           (spk_vld),
        .spike_type_i            (spk_type),
        .spike_ready_o           (spk_rdy),
        .ts_end_i                (ts_end),
        .voltage_potential_i     (vpot),
        .pos_threshold_i         (pos_th),
        .neg_threshold_i         (neg_th),
        .leak_value_i            (leak),
        .weight_type1_i          (w1),
        .weight_type2_i          (w2),
        .weight_type3_i          (w3),
        .weight_type4_i          (w4),
        .pos_reset_i             (pos_rst),
        .neg_reset_i             (neg_rst),
        .ext_voltage_potential_o (ext_v),
        .ext_write_enable_o      (ext_we),
        .spike_o                 (spike),
        .done_o                  (done),
        .busy_o                  (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic do_spike(input logic [1:0] t, input logic with_end);
        spk_vld  = 1'b1;
        spk_type = t;
        ts_end   = with_end;
        cyc();
        spk_vld = 1'b0;
        ts_end  = 1'b0;
    endtask

    task automatic do_end();
        ts_end = 1'b1;
        cyc();
        ts_end = 1'b0;
    endtask

    // Called right after the ts_end edge; the strobe must appear two edges later.
    task automatic wait_wb(input string tag, input logic [7:0] exp_v, input logic exp_spk);
        int n;
        n = 0;
        while (ext_we !== 1'b1 && n < 8) begin
            cyc();
            n++;
        end
        chk({tag, "_latency"}, n, 2);
        chk({tag, "_value"}, ext_v, exp_v);
        chk({tag, "_spike"}, spike, exp_spk);
        chk({tag, "_done"}, done, 1'b1);
        cyc();
        chk({tag, "_strobe_clear"}, {ext_we, spike, done, busy}, 4'b0000);
        chk({tag, "_hold"}, ext_v, exp_v);
    endtask

    always @(posedge clk) if (ext_we === 1'b1) we_seen++;

    initial begin
        rst_n = 1'b0; tick = 1'b0; spk_vld = 1'b0; ts_end = 1'b0; spk_type = 2'd0;
        vpot = 8'd0; pos_th = 8'd50; neg_th = -8'sd50; leak = 8'd0;
        w1 = 8'd0; w2 = 8'd0; w3 = 8'd0; w4 = 8'd0; pos_rst = 8'd0; neg_rst = 8'd0;
        we_seen = 0;
        cyc(); cyc();
        chk("reset_outputs", {ext_v, ext_we, spike, done, busy, spk_rdy}, 13'h0);
        rst_n = 1'b1;
        cyc();

        // Basic integrate: 10+5+5-3-1 = 16
        vpot = 8'd10; w1 = 8'd5; w2 = -8'sd3; leak = -8'sd1;
        do_tick();
        chk("integrate_ready_busy", {spk_rdy, busy}, 2'b11);
        do_spike(2'd0, 1'b0);
        do_spike(2'd0, 1'b0);
        do_spike(2'd1, 1'b0);
        do_end();
        chk("leak_not_ready", spk_rdy, 1'b0);
        wait_wb("basic", 8'h10, 1'b0);

        // Positive fire: 40+20-1 = 59 >= 50
        vpot = 8'd40; w1 = 8'd20; pos_rst = 8'd0;
        do_tick();
        do_spike(2'd0, 1'b0);
        do_end();
        wait_wb("pos_fire", 8'h00, 1'b1);

        // Negative reset: -40-20-1 = -61 <= -50
        vpot = -8'sd40; w3 = -8'sd20; neg_rst = -8'sd10;
        do_tick();
        do_spike(2'd2, 1'b0);
        do_end();
        wait_wb("neg_reset", 8'hF6, 1'b0);

        // Saturation: 120+100 clamps to 127, stays 127; 127 >= 127
        vpot = 8'd120; w4 = 8'd100; leak = 8'd0; pos_th = 8'd127; pos_rst = 8'd5;
        do_tick();
        do_spike(2'd3, 1'b0);
        do_spike(2'd3, 1'b0);
        do_end();
        wait_wb("saturate", 8'h05, 1'b1);

        // Spike in the same cycle as ts_end is integrated
        pos_th = 8'd50; vpot = 8'd0; w1 = 8'd3; leak = 8'd0;
        do_tick();
        do_spike(2'd0, 1'b1);
        wait_wb("same_cycle_end", 8'h03, 1'b0);

        // Empty timestep: 7-2 = 5
        vpot = 8'd7; leak = -8'sd2;
        do_tick();
        do_end();
        wait_wb("empty_ts", 8'h05, 1'b0);

        // tick during INTEGRATE must not reload: 7+3+3 = 13
        leak = 8'd0;
        do_tick();
        do_spike(2'd0, 1'b0);
        do_tick();
        chk("tick_ignored_busy", {busy, spk_rdy}, 2'b11);
        do_spike(2'd0, 1'b0);
        do_end();
        wait_wb("tick_ignored", 8'h0D, 1'b0);

        // Reset mid-INTEGRATE aborts; next timestep restarts from the stored potential
        vpot = 8'd10; w1 = 8'd5;
        do_tick();
        do_spike(2'd0, 1'b0);
        do_spike(2'd0, 1'b0);
        we_seen = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("midop_reset_outputs", {ext_v, ext_we, spike, done, busy, spk_rdy}, 13'h0);
        cyc(); cyc(); cyc();
        chk("midop_no_strobe", we_seen, 0);
        rst_n = 1'b1;
        cyc();
        chk("post_reset_idle", busy, 1'b0);
        do_tick();
        do_end();
        wait_wb("post_reset_run", 8'h0A, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
